// File: rtl/seven_seg_pkg.sv
// rtl/seven_seg_pkg.sv - shared constants, scan states and anode helper for the seven-segment scanner
package seven_seg_pkg;

    localparam logic [7:0] SEG_BLANK = 8'hFF;

    typedef enum logic {
        BLANK,
        SHOW
    } scan_state_t;

    // Active-low one-hot anode vector; callers truncate to their digit count.
    function automatic logic [31:0] anode_onehot_n(input int unsigned sel);
        return ~(32'd1 << sel);
    endfunction

endpackage

// File: rtl/bcd_to_seven.sv
// rtl/bcd_to_seven.sv - hex nibble to active-low gfedcba segments, dp bit held off
module bcd_to_seven
    import seven_seg_pkg::*;
(
    input  logic [3:0] bin_in,
    output logic [7:0] sseg_out
);

    always_comb begin
        sseg_out = SEG_BLANK;
        case (bin_in)
            4'h0: sseg_out = 8'hC0;
            4'h1: sseg_out = 8'hF9;
            4'h2: sseg_out = 8'hA4;
            4'h3: sseg_out = 8'hB0;
            4'h4: sseg_out = 8'h99;
            4'h5: sseg_out = 8'h92;
            4'h6: sseg_out = 8'h82;
            4'h7: sseg_out = 8'hF8;
            4'h8: sseg_out = 8'h80;
            4'h9: sseg_out = 8'h90;
            4'hA: sseg_out = 8'h88;
            4'hB: sseg_out = 8'h83;
            4'hC: sseg_out = 8'hC6;
            4'hD: sseg_out = 8'hA1;
            4'hE: sseg_out = 8'h86;
            4'hF: sseg_out = 8'h8E;
        endcase
    end

endmodule

// File: rtl/seven_seg_scanner.sv
// rtl/seven_seg_scanner.sv - round-robin multiplexed seven-segment driver with blanking guard and double-buffered data
module seven_seg_scanner
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   enable_mask,
    input  logic                    blank_lz,
    input  logic                    load,
    output logic [7:0]              sseg_out,
    output logic [NUM_DIGITS-1:0]   an_out,
    output logic                    frame_done
);

    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    scan_state_t               state, state_next;
    logic [CNT_W-1:0]          cnt;
    logic [IDX_W-1:0]          idx;
    logic [4*NUM_DIGITS-1:0]   pend_digits, shd_digits;
    logic [NUM_DIGITS-1:0]     pend_dp, shd_dp;
    logic                      pend_flag;

    logic                      slot_end, frame_end;
    logic [3:0]                nib;
    logic                      dp_sel, en_sel, lz_sel, zero_run;
    logic [7:0]                dec_seg, seg_next;
    logic [NUM_DIGITS-1:0]     an_next;

    assign slot_end  = (cnt == CNT_LAST);
    assign frame_end = slot_end && (idx == IDX_LAST);

    bcd_to_seven u_dec (
        .bin_in   (nib),
        .sseg_out (dec_seg)
    );

    always_comb begin
        state_next = state;
        case (state)
            BLANK: if (cnt == BLANK_LAST) state_next = SHOW;
            SHOW:  if (slot_end)          state_next = BLANK;
            default: state_next = BLANK;
        endcase
    end

    // Walk from the top digit down so zero_run marks "this nibble and all above are zero".
    always_comb begin
        nib      = 4'd0;
        dp_sel   = 1'b0;
        en_sel   = 1'b0;
        lz_sel   = 1'b0;
        zero_run = 1'b1;
        for (int d = NUM_DIGITS - 1; d >= 0; d--) begin
            zero_run = zero_run && (shd_digits[d*4 +: 4] == 4'd0);
            if (idx == IDX_W'(d)) begin
                nib    = shd_digits[d*4 +: 4];
                dp_sel = shd_dp[d];
                en_sel = enable_mask[d];
                lz_sel = zero_run && (d != 0);
            end
        end
    end

    always_comb begin
        seg_next = SEG_BLANK;
        an_next  = '1;
        if (state == SHOW && en_sel) begin
            an_next = NUM_DIGITS'(anode_onehot_n(32'(idx)));
            if (!(blank_lz && lz_sel && !dp_sel))
                seg_next = {dec_seg[7] & ~dp_sel, dec_seg[6:0]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= BLANK;
            cnt         <= '0;
            idx         <= '0;
            pend_digits <= '0;
            pend_dp     <= '0;
            pend_flag   <= 1'b0;
            shd_digits  <= '0;
            shd_dp      <= '0;
            sseg_out    <= SEG_BLANK;
            an_out      <= '1;
            frame_done  <= 1'b0;
        end else begin
            state      <= state_next;
            cnt        <= slot_end ? '0 : cnt + 1'b1;
            if (slot_end)
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            sseg_out   <= seg_next;
            an_out     <= an_next;
            frame_done <= frame_end;
            // Shadow only changes on the edge entering slot 0, so a frame never tears.
            if (frame_end) begin
                pend_flag <= 1'b0;
                if (load) begin
                    shd_digits <= digits_in;
                    shd_dp     <= dp_in;
                end else if (pend_flag) begin
                    shd_digits <= pend_digits;
                    shd_dp     <= pend_dp;
                end
            end else if (load) begin
                pend_digits <= digits_in;
                pend_dp     <= dp_in;
                pend_flag   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// tb/tb_seven_seg_scanner.sv - directed self-checking bench for seven_seg_scanner
module tb_seven_seg_scanner;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] digits_in;
    logic [3:0]  dp_in;
    logic [3:0]  enable_mask;
    logic        blank_lz;
    logic        load;
    logic [7:0]  sseg_out;
    logic [3:0]  an_out;
    logic        frame_done;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    seven_seg_scanner #(
        .NUM_DIGITS   (4),
        .REFRESH_DIV  (8),
        .BLANK_CYCLES (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .digits_in   (digits_in),
        .dp_in       (dp_in),
        .enable_mask (enable_mask),
        .blank_lz    (blank_lz),
        .load        (load),
        .sseg_out    (sseg_out),
        .an_out      (an_out),
        .frame_done  (frame_done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // One 32-cycle frame; expected segments per digit given for SHOW cycles.
    task automatic run_frame(input logic [7:0] s0, input logic [7:0] s1,
                             input logic [7:0] s2, input logic [7:0] s3,
                             input logic [3:0] mask_exp, input int load_at,
                             input logic [15:0] ld_val, input logic [3:0] ld_dp);
        logic [7:0] segs [4];
        logic [3:0] ea;
        logic [7:0] es;
        int d, q;
        segs[0] = s0; segs[1] = s1; segs[2] = s2; segs[3] = s3;
        for (int p = 0; p < 32; p++) begin
            if (p == load_at) begin
                load      = 1'b1;
                digits_in = ld_val;
                dp_in     = ld_dp;
            end
            tick();
            load = 1'b0;
            d = p / 8;
            q = p % 8;
            ea = 4'hF;
            es = 8'hFF;
            if (q >= 2 && mask_exp[d]) begin
                ea[d] = 1'b0;
                es    = segs[d];
            end
            check("an_out", 32'(an_out), 32'(ea));
            check("sseg_out", 32'(sseg_out), 32'(es));
            check("frame_done", 32'(frame_done), (p == 31) ? 32'd1 : 32'd0);
        end
    endtask

    initial begin
        reset       = 1'b1;
        digits_in   = 16'h0000;
        dp_in       = 4'b0000;
        enable_mask = 4'b1111;
        blank_lz    = 1'b0;
        load        = 1'b0;
        repeat (3) tick();
        check("rst_sseg", 32'(sseg_out), 32'hFF);
        check("rst_an", 32'(an_out), 32'hF);
        check("rst_fd", 32'(frame_done), 32'd0);

        reset = 1'b0;
        cyc   = -1;
        run_frame(8'hC0, 8'hC0, 8'hC0, 8'hC0, 4'b1111, 0, 16'h1234, 4'b0000);
        run_frame(8'h99, 8'hB0, 8'hA4, 8'hF9, 4'b1111, 10, 16'hABCD, 4'b0000);
        run_frame(8'hA1, 8'hC6, 8'h83, 8'h88, 4'b1111, 31, 16'h1234, 4'b0010);
        run_frame(8'h99, 8'h30, 8'hA4, 8'hF9, 4'b1111, 31, 16'h0070, 4'b0000);

        blank_lz = 1'b1;
        run_frame(8'hC0, 8'hF8, 8'hFF, 8'hFF, 4'b1111, -1, 16'h0000, 4'b0000);
        enable_mask = 4'b1011;
        run_frame(8'hC0, 8'hF8, 8'hFF, 8'hFF, 4'b1011, 31, 16'h0070, 4'b0100);
        enable_mask = 4'b1111;
        run_frame(8'hC0, 8'hF8, 8'h40, 8'hFF, 4'b1111, -1, 16'h0000, 4'b0000);

        // Mid-frame reset with a load still pending.
        cyc = -1;
        for (int p = 0; p <= 20; p++) begin
            if (p == 5) begin
                load      = 1'b1;
                digits_in = 16'h1234;
                dp_in     = 4'b0000;
            end
            tick();
            load = 1'b0;
        end
        check("mid_an_before", 32'(an_out), 32'hB);
        reset = 1'b1;
        tick();
        check("mid_rst_sseg", 32'(sseg_out), 32'hFF);
        check("mid_rst_an", 32'(an_out), 32'hF);
        check("mid_rst_fd", 32'(frame_done), 32'd0);
        reset    = 1'b0;
        blank_lz = 1'b0;
        cyc      = -1;
        run_frame(8'hC0, 8'hC0, 8'hC0, 8'hC0, 4'b1111, -1, 16'h0000, 4'b0000);
        run_frame(8'hC0, 8'hC0, 8'hC0, 8'hC0, 4'b1111, -1, 16'h0000, 4'b0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
